chip_mmc1x: RTL and testbench
=============================

# chip_mmc1x

Parametrised MMC1-family serial-load banking core for the mapper layer. It decodes 5-bit serial writes into four bank/control registers and drives PRG/CHR/WRAM bank lines and the CIRAM A10 line. It covers MMC1A/MMC1B revision differences, optional back-to-back write filtering, SUROM outer-PRG banking and SOROM/SXROM WRAM banking. It sits inside a mapper wrapper, which builds memory controls from its outputs, and is reachable through the save-state bus.

## Interface
- REV, 1, 0 = MMC1A (WRAM always enabled), 1 = MMC1B (WRAM gated by PRG reg bit 4)
- FILTER, 1, 1 = ignore a serial write whose preceding M2 cycle was also a CPU write
- OUTER_PRG, 0, 1 = prg_addr[18] from selected CHR reg bit 4 (SUROM 512K)
- WRAM_BANKING, 0, 1 = wram_bank from selected CHR reg bits [3:2] (SOROM/SXROM)

Ports:
- m2  in  1  CPU M2; all state updates on the falling edge
- rst  in  1  reset, asynchronous, active-high
- cpu_addr  in  2  CPU A[14:13]
- cpu_ce_n  in  1  low = CPU $8000-$FFFF
- cpu_rw  in  1  1 = read
- cpu_d7, cpu_d0  in  1 each  CPU data bits
- ppu_addr  in  3  PPU A[12:10]
- wram_ce  out  1  $6000-$7FFF select, enable applied
- prg_ce_n  out  1  low on CPU read in $8000-$FFFF
- prg_addr  out  5  PRG A[18:14]
- chr_addr  out  5  CHR A[16:12]
- wram_bank  out  2  WRAM A[14:13]
- ciram_a10  out  1  nametable select
- sst_act, sst_we  in  1 each  save-state active / register write strobe
- sst_addr  in  8  save-state register index
- sst_wdat  in  8  save-state write data
- sst_rdat  out  8  save-state read data

## Operation
- CPU write = !cpu_ce_n & !cpu_rw, sampled on m2 falling edge. rw_prev holds cpu_rw from the previous falling edge.
- D7 = 1 write: clear ctr and sreg, force ctrl[3:2] = 11. Never filtered.
- D7 = 0 write, accepted only if !FILTER or rw_prev = 1:
  - sreg <= {d0, sreg[4:1]}
  - if ctr = 4: commit shifted value to the register selected by A[14:13] (0 ctrl, 1 chr0, 2 chr1, 3 prg), then ctr <= 0 and sreg <= 0
  - otherwise ctr <= ctr + 1
- Mirroring (ctrl[1:0]): 00 → 0; 01 → 1; 10 → ppu_addr[10]; 11 → ppu_addr[11].
- PRG inner bank (ctrl[3:2]):
  - 0x: {prg[3:1], A14}
  - 10: A14 = 0 → 0, else prg[3:0]
  - 11: A14 = 1 → 0xF, else prg[3:0]
- Selected CHR reg: ctrl[4] = 0 or ppu_addr[12] = 0 → chr0; otherwise chr1.
- prg_addr[18] = OUTER_PRG ? selected_chr[4] : 0.
- chr_addr: ctrl[4] = 0 → {chr0[4:1], ppu_addr[12]}; otherwise selected_chr.
- wram_ce = cpu_ce_n & A[14:13] = 11 & (REV = 0 | prg[4] = 0).
- wram_bank = WRAM_BANKING ? selected_chr[3:2] : 00.
- prg_ce_n = !(!cpu_ce_n & cpu_rw).
- Save state: while sst_act, CPU writes are ignored and rw_prev is still tracked. Indices 0..4 = ctrl, chr0, chr1, prg, sreg; 5 = {4'b0, rw_prev, ctr}. sst_we loads the indexed register on the m2 falling edge. sst_rdat returns the indexed value, zero-extended; any other index returns 0xFF.

## Timing
- Reset values: ctrl = 0x0C, chr0 = chr1 = prg = 0, sreg = 0, ctr = 0, rw_prev = 1. Resulting outputs: ciram_a10 = 0, prg_addr = 0x00 at $8000 and 0x0F at $C000, chr_addr = {0000, ppu_addr[12]}, wram_ce enabled.
- Bank outputs are combinational from registers and addresses. A register commit is visible immediately after the committing m2 falling edge.
- Priority: rst > sst_act > D7 reset > shift.
- rst mid-sequence discards the partial shift. The next D7 = 0 write is bit 0.
- A commit and a D7 = 1 write cannot coincide; D7 = 1 takes the write.
- With FILTER = 1, an RMW double write (e.g. INC) shifts only the first write. Two writes separated by a read both shift.

## Structure
- Package mmc1x_pkg: register index constants (REG_CTRL..REG_PRG), save-state index constants (0..5), PRG mode enum, mirroring enum.
- One sub-module, mmc1x_serial: owns ctr, sreg, rw_prev and the filter; outputs commit strobe, commit data and D7-reset strobe. Banking decode and save-state mux stay in the top.

## Test plan
- Reset, then read $C000 → prg_addr = 0x0F; read $8000 → 0x00; ciram_a10 = 0.
- Write $80 to $8000, then 5 writes of bits 0,1,1,0,1 (value 0x16) to $8000 → ctrl = 0x16: ciram_a10 = ppu_addr[10], PRG mode 01 (32K), chr 4K mode.
- FILTER = 1, two consecutive writes with d0 = 1, then 4 separated writes → one write dropped; commit on the 5th accepted write. FILTER = 0 → the 5th raw write commits.
- REV = 1, load prg = 0x10 → wram_ce = 0 for $6000. REV = 0 → wram_ce = 1.
- OUTER_PRG = 1, WRAM_BANKING = 1, chr0 = 0x1C → prg_addr[18] = 1, wram_bank = 11.
- sst_act: write indices 0..5, read them back identical. CPU writes during sst_act leave state unchanged. Index 9 reads 0xFF.

Source files
------------

// File: rtl/mmc1x_pkg.sv
// Shared constants and enums for the MMC1-family banking core.
package mmc1x_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CHR0 = 2'd1;
  localparam logic [1:0] REG_CHR1 = 2'd2;
  localparam logic [1:0] REG_PRG  = 2'd3;

  localparam logic [7:0] SST_CTRL = 8'd0;
  localparam logic [7:0] SST_CHR0 = 8'd1;
  localparam logic [7:0] SST_CHR1 = 8'd2;
  localparam logic [7:0] SST_PRG  = 8'd3;
  localparam logic [7:0] SST_SREG = 8'd4;
  localparam logic [7:0] SST_STAT = 8'd5;

  typedef enum logic [1:0] {
    PRG_32K_A  = 2'b00,
    PRG_32K_B  = 2'b01,
    PRG_FIX_LO = 2'b10,
    PRG_FIX_HI = 2'b11
  } prg_mode_e;

  typedef enum logic [1:0] {
    MIR_ONE_LO = 2'b00,
    MIR_ONE_HI = 2'b01,
    MIR_VERT   = 2'b10,
    MIR_HORZ   = 2'b11
  } mirror_e;

endpackage

// File: rtl/mmc1x_if.sv
// CPU/PPU bus, bank outputs and save-state port of the MMC1 core.
interface mmc1x_if;
  logic [1:0] cpu_addr;
  logic       cpu_ce_n;
  logic       cpu_rw;
  logic       cpu_d7;
  logic       cpu_d0;
  logic [2:0] ppu_addr;
  logic       wram_ce;
  logic       prg_ce_n;
  logic [4:0] prg_addr;
  logic [4:0] chr_addr;
  logic [1:0] wram_bank;
  logic       ciram_a10;
  logic       sst_act;
  logic       sst_we;
  logic [7:0] sst_addr;
  logic [7:0] sst_wdat;
  logic [7:0] sst_rdat;

  modport master (
    output cpu_addr, cpu_ce_n, cpu_rw, cpu_d7, cpu_d0, ppu_addr,
           sst_act, sst_we, sst_addr, sst_wdat,
    input  wram_ce, prg_ce_n, prg_addr, chr_addr, wram_bank, ciram_a10, sst_rdat
  );

  modport slave (
    input  cpu_addr, cpu_ce_n, cpu_rw, cpu_d7, cpu_d0, ppu_addr,
           sst_act, sst_we, sst_addr, sst_wdat,
    output wram_ce, prg_ce_n, prg_addr, chr_addr, wram_bank, ciram_a10, sst_rdat
  );
endinterface

// File: rtl/mmc1x_serial.sv
// 5-bit serial loader: shift register, bit counter, D7 reset and
// back-to-back write filter. Produces commit/reset strobes for the top.
module mmc1x_serial #(
  parameter bit FILTER = 1'b1
) (
  input  logic       m2,
  input  logic       rst,
  input  logic       cpu_wr,
  input  logic       cpu_rw,
  input  logic       d7,
  input  logic       d0,
  input  logic       sst_load_sreg,
  input  logic       sst_load_stat,
  input  logic [4:0] sst_wdat,
  output logic       commit,
  output logic [4:0] commit_data,
  output logic       d7_rst,
  output logic [4:0] sreg,
  output logic [2:0] ctr,
  output logic       rw_prev
);

  logic       accept;
  logic [4:0] shifted;

  always_comb begin
    d7_rst      = cpu_wr & d7;
    accept      = cpu_wr & ~d7 & ((FILTER == 1'b0) | rw_prev);
    shifted     = {d0, sreg[4:1]};
    commit      = accept & (ctr == 3'd4);
    commit_data = shifted;
  end

  always_ff @(negedge m2 or posedge rst) begin
    if (rst) begin
      sreg    <= 5'd0;
      ctr     <= 3'd0;
      rw_prev <= 1'b1;
    end else begin
      rw_prev <= cpu_rw;
      if (sst_load_sreg) sreg <= sst_wdat;
      if (sst_load_stat) begin
        ctr     <= sst_wdat[2:0];
        rw_prev <= sst_wdat[3];
      end
      if (d7_rst) begin
        sreg <= 5'd0;
        ctr  <= 3'd0;
      end else if (accept) begin
        if (ctr == 3'd4) begin
          sreg <= 5'd0;
          ctr  <= 3'd0;
        end else begin
          sreg <= shifted;
          ctr  <= ctr + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/chip_mmc1x.sv
// MMC1-family banking core: bank/control registers, PRG/CHR/WRAM decode,
// mirroring and save-state access.
module chip_mmc1x
  import mmc1x_pkg::*;
#(
  parameter bit REV          = 1'b0,
  parameter bit FILTER       = 1'b1,
  parameter bit OUTER_PRG    = 1'b0,
  parameter bit WRAM_BANKING = 1'b0
) (
  input logic   m2,
  input logic   rst,
  mmc1x_if.slave bus
);

  logic [4:0] ctrl, chr0, chr1, prg;
  logic       commit, d7_rst, rw_prev;
  logic [4:0] commit_data, sreg, sel_chr;
  logic [2:0] ctr;
  logic [3:0] prg_inner;
  logic       a14, cpu_wr, sst_wr;
  logic       unused_wdat;

  assign unused_wdat = ^bus.sst_wdat[7:5];
  assign sst_wr      = bus.sst_act & bus.sst_we;
  // Save-state mode locks the CPU out of the serial port entirely.
  assign cpu_wr      = ~bus.cpu_ce_n & ~bus.cpu_rw & ~bus.sst_act;
  assign a14         = bus.cpu_addr[1];

  mmc1x_serial #(.FILTER(FILTER)) u_serial (
    .m2            (m2),
    .rst           (rst),
    .cpu_wr        (cpu_wr),
    .cpu_rw        (bus.cpu_rw),
    .d7            (bus.cpu_d7),
    .d0            (bus.cpu_d0),
    .sst_load_sreg (sst_wr && bus.sst_addr == SST_SREG),
    .sst_load_stat (sst_wr && bus.sst_addr == SST_STAT),
    .sst_wdat      (bus.sst_wdat[4:0]),
    .commit        (commit),
    .commit_data   (commit_data),
    .d7_rst        (d7_rst),
    .sreg          (sreg),
    .ctr           (ctr),
    .rw_prev       (rw_prev)
  );

  always_ff @(negedge m2 or posedge rst) begin
    if (rst) begin
      ctrl <= 5'h0C;
      chr0 <= 5'd0;
      chr1 <= 5'd0;
      prg  <= 5'd0;
    end else if (sst_wr) begin
      case (bus.sst_addr)
        SST_CTRL: ctrl <= bus.sst_wdat[4:0];
        SST_CHR0: chr0 <= bus.sst_wdat[4:0];
        SST_CHR1: chr1 <= bus.sst_wdat[4:0];
        SST_PRG:  prg  <= bus.sst_wdat[4:0];
        default: ;
      endcase
    end else if (d7_rst) begin
      ctrl[3:2] <= 2'b11;
    end else if (commit) begin
      case (bus.cpu_addr)
        REG_CTRL: ctrl <= commit_data;
        REG_CHR0: chr0 <= commit_data;
        REG_CHR1: chr1 <= commit_data;
        REG_PRG:  prg  <= commit_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    sel_chr   = (ctrl[4] && bus.ppu_addr[2]) ? chr1 : chr0;
    prg_inner = prg[3:0];
    case (prg_mode_e'(ctrl[3:2]))
      PRG_32K_A, PRG_32K_B: prg_inner = {prg[3:1], a14};
      PRG_FIX_LO:           prg_inner = a14 ? prg[3:0] : 4'h0;
      PRG_FIX_HI:           prg_inner = a14 ? 4'hF : prg[3:0];
      default:              prg_inner = prg[3:0];
    endcase
    bus.prg_addr  = {(OUTER_PRG == 1'b1) ? sel_chr[4] : 1'b0, prg_inner};
    bus.chr_addr  = ctrl[4] ? sel_chr : {chr0[4:1], bus.ppu_addr[2]};
    bus.wram_bank = (WRAM_BANKING == 1'b1) ? sel_chr[3:2] : 2'b00;
    bus.wram_ce   = bus.cpu_ce_n & (bus.cpu_addr == 2'b11) & ((REV == 1'b0) | ~prg[4]);
    bus.prg_ce_n  = ~(~bus.cpu_ce_n & bus.cpu_rw);
    bus.ciram_a10 = 1'b0;
    case (mirror_e'(ctrl[1:0]))
      MIR_ONE_LO: bus.ciram_a10 = 1'b0;
      MIR_ONE_HI: bus.ciram_a10 = 1'b1;
      MIR_VERT:   bus.ciram_a10 = bus.ppu_addr[0];
      MIR_HORZ:   bus.ciram_a10 = bus.ppu_addr[1];
      default:    bus.ciram_a10 = 1'b0;
    endcase
    case (bus.sst_addr)
      SST_CTRL: bus.sst_rdat = {3'b0, ctrl};
      SST_CHR0: bus.sst_rdat = {3'b0, chr0};
      SST_CHR1: bus.sst_rdat = {3'b0, chr1};
      SST_PRG:  bus.sst_rdat = {3'b0, prg};
      SST_SREG: bus.sst_rdat = {3'b0, sreg};
      SST_STAT: bus.sst_rdat = {4'b0, rw_prev, ctr};
      default:  bus.sst_rdat = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_chip_mmc1x.sv
// Scoreboard bench for chip_mmc1x: two parameter sets driven in lockstep
// against a register-level reference model.
module tb_chip_mmc1x;

  typedef struct {
    logic       rst;
    logic [1:0] addr;
    logic       ce_n, rw, d7, d0;
    logic [2:0] ppu;
    logic       act, we;
    logic [7:0] sa, sd;
  } stim_t;

  typedef struct {
    logic [4:0] prg, chr;
    logic       wce, pce, a10;
    logic [1:0] wb;
    logic [7:0] rd;
  } exp_t;

  logic m2 = 1'b1;
  logic rst = 1'b1;
  always #5 m2 = ~m2;

  mmc1x_if if0 ();
  mmc1x_if if1 ();

  chip_mmc1x #(.REV(1'b0), .FILTER(1'b1), .OUTER_PRG(1'b0), .WRAM_BANKING(1'b0))
    dut0 (.m2(m2), .rst(rst), .bus(if0));
  chip_mmc1x #(.REV(1'b1), .FILTER(1'b0), .OUTER_PRG(1'b1), .WRAM_BANKING(1'b1))
    dut1 (.m2(m2), .rst(rst), .bus(if1));

  int errors = 0;
  int checks = 0;
  exp_t q0[$];
  exp_t q1[$];

  int m_reg[2][4];
  int m_sreg[2], m_ctr[2], m_rwp[2];

  function automatic void model_reset(int k);
    m_reg[k][0] = 12; m_reg[k][1] = 0; m_reg[k][2] = 0; m_reg[k][3] = 0;
    m_sreg[k] = 0; m_ctr[k] = 0; m_rwp[k] = 1;
  endfunction

  function automatic exp_t model_out(int k, stim_t s);
    exp_t e;
    int ctrl, prg, sel, inner, a14, m;
    ctrl = m_reg[k][0];
    prg  = m_reg[k][3];
    sel  = (((ctrl / 16) % 2 == 1) && s.ppu[2]) ? m_reg[k][2] : m_reg[k][1];
    a14  = int'(s.addr[1]);
    m    = (ctrl / 4) % 4;
    if (m < 2)       inner = (prg % 16) - (prg % 2) + a14;
    else if (m == 2) inner = (a14 == 1) ? prg % 16 : 0;
    else             inner = (a14 == 1) ? 15 : prg % 16;
    if (k == 1 && sel >= 16) inner = inner + 16;
    e.prg = 5'(inner);
    if (ctrl >= 16) e.chr = 5'(sel);
    else            e.chr = 5'(m_reg[k][1] - (m_reg[k][1] % 2) + int'(s.ppu[2]));
    e.wce = s.ce_n && s.addr == 2'b11 && (k == 0 || prg < 16);
    e.pce = !(!s.ce_n && s.rw);
    e.wb  = (k == 1) ? 2'((sel / 4) % 4) : 2'd0;
    case (ctrl % 4)
      0: e.a10 = 1'b0;
      1: e.a10 = 1'b1;
      2: e.a10 = s.ppu[0];
      default: e.a10 = s.ppu[1];
    endcase
    if (s.sa < 4)       e.rd = 8'(m_reg[k][s.sa]);
    else if (s.sa == 4) e.rd = 8'(m_sreg[k]);
    else if (s.sa == 5) e.rd = 8'(m_rwp[k] * 8 + m_ctr[k]);
    else                e.rd = 8'hFF;
    return e;
  endfunction

  function automatic void model_update(int k, stim_t s);
    int nrw, v;
    nrw = int'(s.rw);
    if (s.act) begin
      if (s.we) begin
        if (s.sa < 4)       m_reg[k][s.sa] = int'(s.sd) % 32;
        else if (s.sa == 4) m_sreg[k] = int'(s.sd) % 32;
        else if (s.sa == 5) begin
          m_ctr[k] = int'(s.sd) % 8;
          nrw = (int'(s.sd) / 8) % 2;
        end
      end
    end else if (!s.ce_n && !s.rw) begin
      if (s.d7) begin
        m_ctr[k] = 0; m_sreg[k] = 0;
        if ((m_reg[k][0] / 4) % 4 != 3) m_reg[k][0] = m_reg[k][0] - ((m_reg[k][0] / 4) % 4) * 4 + 12;
      end else if (k == 1 || m_rwp[k] == 1) begin
        v = m_sreg[k] / 2 + int'(s.d0) * 16;
        if (m_ctr[k] == 4) begin
          m_reg[k][s.addr] = v; m_ctr[k] = 0; m_sreg[k] = 0;
        end else begin
          m_sreg[k] = v; m_ctr[k] = m_ctr[k] + 1;
        end
      end
    end
    m_rwp[k] = nrw;
  endfunction

  task automatic chk(string name, int k, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  task automatic cmp(int k, exp_t e, logic [4:0] pa, logic [4:0] ca, logic wce, logic pce,
                     logic [1:0] wb, logic a10, logic [7:0] rd);
    chk("prg_addr", k, int'(pa), int'(e.prg));
    chk("chr_addr", k, int'(ca), int'(e.chr));
    chk("wram_ce", k, int'(wce), int'(e.wce));
    chk("prg_ce_n", k, int'(pce), int'(e.pce));
    chk("wram_bank", k, int'(wb), int'(e.wb));
    chk("ciram_a10", k, int'(a10), int'(e.a10));
    chk("sst_rdat", k, int'(rd), int'(e.rd));
  endtask

  // Monitor: outputs are stable mid-cycle, between the input update and the next falling edge.
  always @(posedge m2) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp(0, e, if0.prg_addr, if0.chr_addr, if0.wram_ce, if0.prg_ce_n, if0.wram_bank,
          if0.ciram_a10, if0.sst_rdat);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp(1, e, if1.prg_addr, if1.chr_addr, if1.wram_ce, if1.prg_ce_n, if1.wram_bank,
          if1.ciram_a10, if1.sst_rdat);
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.addr = 0; s.ce_n = 1; s.rw = 1; s.d7 = 0; s.d0 = 0; s.ppu = 0;
    s.act = 0; s.we = 0; s.sa = 0; s.sd = 0;
    return s;
  endfunction

  task automatic step(stim_t s);
    @(negedge m2);
    #1;
    rst = s.rst;
    if0.cpu_addr = s.addr; if1.cpu_addr = s.addr;
    if0.cpu_ce_n = s.ce_n; if1.cpu_ce_n = s.ce_n;
    if0.cpu_rw = s.rw;     if1.cpu_rw = s.rw;
    if0.cpu_d7 = s.d7;     if1.cpu_d7 = s.d7;
    if0.cpu_d0 = s.d0;     if1.cpu_d0 = s.d0;
    if0.ppu_addr = s.ppu;  if1.ppu_addr = s.ppu;
    if0.sst_act = s.act;   if1.sst_act = s.act;
    if0.sst_we = s.we;     if1.sst_we = s.we;
    if0.sst_addr = s.sa;   if1.sst_addr = s.sa;
    if0.sst_wdat = s.sd;   if1.sst_wdat = s.sd;
    for (int k = 0; k < 2; k++) begin
      if (s.rst) model_reset(k);
      if (k == 0) q0.push_back(model_out(0, s));
      else        q1.push_back(model_out(1, s));
      if (!s.rst) model_update(k, s);
    end
  endtask

  task automatic wr(logic [1:0] a, logic d7, logic d0);
    stim_t s = idle();
    s.addr = a; s.ce_n = 0; s.rw = 0; s.d7 = d7; s.d0 = d0;
    step(s);
  endtask

  task automatic rd(logic [1:0] a, logic [2:0] p);
    stim_t s = idle();
    s.addr = a; s.ce_n = 0; s.ppu = p;
    step(s);
  endtask

  task automatic sst(logic we, logic [7:0] sa, logic [7:0] sd);
    stim_t s = idle();
    s.act = 1; s.we = we; s.sa = sa; s.sd = sd;
    step(s);
  endtask

  task automatic ser_load(logic [1:0] a, logic [4:0] v);
    wr(a, 1, 0);
    rd(a, 0);
    for (int i = 0; i < 5; i++) begin
      wr(a, 0, v[i]);
      rd(a, 3'(i));
    end
  endtask

  initial begin
    stim_t s;
    logic [7:0] vals [6];
    s = idle(); s.rst = 1;
    step(s); step(s);
    rd(2'b10, 0);
    rd(2'b00, 4);
    ser_load(2'b00, 5'h16);
    for (int p = 0; p < 8; p++) rd(2'(p % 4), 3'(p));
    // Filter: back-to-back pair then four separated writes.
    wr(2'b01, 1, 0); rd(0, 0);
    wr(2'b01, 0, 1); wr(2'b01, 0, 1);
    for (int i = 0; i < 4; i++) begin rd(0, 0); wr(2'b01, 0, 1'(i % 2)); end
    sst(0, 8'd1, 0); sst(0, 8'd4, 0); sst(0, 8'd5, 0);
    ser_load(2'b11, 5'h10);
    s = idle(); s.addr = 2'b11; step(s);
    ser_load(2'b00, 5'h0C);
    ser_load(2'b01, 5'h1C);
    rd(2'b00, 0); rd(2'b10, 4);
    vals = '{8'h15, 8'h0A, 8'h1F, 8'h11, 8'h09, 8'h0C};
    for (int i = 0; i < 6; i++) sst(1, 8'(i), vals[i]);
    for (int i = 0; i < 6; i++) sst(0, 8'(i), 0);
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.act = 1; s.ce_n = 0; s.rw = 0; s.d7 = 1'(i % 2); s.d0 = 1; s.sa = 8'(i + 2);
      step(s);
    end
    sst(0, 8'd9, 0);
    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.addr = 2'($urandom_range(0, 3));
      s.ce_n = ($urandom_range(0, 3) == 0);
      s.rw   = 1'($urandom_range(0, 1));
      s.d7   = ($urandom_range(0, 15) == 0);
      s.d0   = 1'($urandom_range(0, 1));
      s.ppu  = 3'($urandom_range(0, 7));
      s.act  = ($urandom_range(0, 15) == 0);
      s.we   = 1'($urandom_range(0, 1));
      s.sa   = 8'($urandom_range(0, 7));
      s.sd   = 8'($urandom_range(0, 255));
      if (s.sa == 8'd5) s.sd = 8'($urandom_range(0, 1) * 8 + $urandom_range(0, 4));
      s.rst  = ($urandom_range(0, 99) == 0);
      step(s);
    end
    repeat (3) @(posedge m2);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
